fir_folded_param: RTL and testbench
===================================

# fir_folded_param

Parametrised folded FIR filter: one signed multiply-accumulate unit time-shared over TAPS coefficients, with a run-time writable coefficient bank, an en/ready input handshake and a one-cycle valid output strobe. It succeeds the fixed 8-tap, 8-bit folded filter. Tap count, data, coefficient and output widths are generics, and it adds a flush control and configurable output scaling. It sits between a sample source that drives en/ready and a consumer that samples y on valid.

## Interface
- TAPS, 8: number of taps, ≥2.
- DW, 8: input sample width, signed.
- CW, 8: coefficient width, signed.
- OW, 8: output width, signed.
- SHIFT, 7: arithmetic right shift applied to the accumulator before output; 0 ≤ SHIFT < ACC_W.
- ACC_W (localparam): DW+CW+$clog2(TAPS).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- en  in  1  sample strobe; accepted when en && ready.
- x  in  DW  signed input sample.
- flush  in  1  synchronous clear of delay line and accumulator; aborts any computation in progress.
- coef_we  in  1  coefficient write enable.
- coef_addr  in  $clog2(TAPS)  coefficient index; 0 multiplies the newest sample.
- coef_data  in  CW  signed coefficient value.
- ready  out  1  high when a new sample can be accepted (FSM in IDLE).
- valid  out  1  one-cycle strobe; y is new.
- y  out  OW  signed filter output; held between strobes.

## Operation
- FSM states: IDLE, MAC.
- IDLE → MAC on en && ready && !flush. On that edge: x shifts into delay line slot 0 and older samples move up one slot (slot TAPS-1 discarded); acc ← 0; idx ← 0.
- MAC: each cycle acc ← acc + d[idx]*c[idx] at full ACC_W precision; idx increments. The product is DW+CW bits, sign-extended.
- On the edge of the MAC cycle where idx = TAPS-1:
  - final sum S = acc + d[TAPS-1]*c[TAPS-1];
  - y ← scale(S); valid ← 1 for one cycle; state → IDLE.
- scale(S) = S >>> SHIFT, arithmetic shift with floor and no rounding, then reduced to OW bits (see Configuration).
- ready = (state == IDLE), combinational. en is ignored while ready = 0, so no sample is lost silently; the source must hold it.
- flush, any state: delay line ← 0, acc ← 0, idx ← 0, state → IDLE, no valid. y keeps its last value. flush wins over a simultaneous en; that sample is discarded.
- Coefficient bank (TAPS × CW registers): c[coef_addr] ← coef_data on coef_we && ready. coef_we is ignored while ready = 0, so coefficients are constant for the whole computation. coef_addr ≥ TAPS is ignored. A write and an accepted sample in the same cycle are both performed; the new coefficient is used by that sample.
- Reset (rst low, any time, including mid-MAC): state IDLE, delay line 0, coefficients 0, acc 0, idx 0, y 0, valid 0. ready reads 1 during and after reset. All inputs are ignored while rst is low.

## Timing
- Sample accepted at edge t. MAC occupies cycles t+1 … t+TAPS. valid = 1 and the new y appear after edge t+TAPS, i.e. in the cycle following the last MAC cycle; latency is TAPS+1 cycles.
- ready returns to 1 in the same cycle valid is high, so a back-to-back en is accepted there.
- Maximum throughput: one sample per TAPS+1 cycles.
- valid is registered and high for exactly one cycle per accepted, unflushed sample.
- The critical path is one DW×CW multiply plus an ACC_W adder, which is single-cycle.

## Configuration
- FIR_SAT_EN defined: the shifted value is clamped to [−2^(OW−1), 2^(OW−1)−1].
- FIR_SAT_EN undefined: the shifted value is truncated to its low OW bits (two's-complement wrap).

## Test plan
- Impulse, with SHIFT=0, OW=16 and coefficients 1..8 at addresses 0..7: x = 1 then seven samples of 0. The eight outputs are 1,2,3,4,5,6,7,8; a ninth sample of 0 gives 0.
- Latency and handshake, default parameters: en pulsed at edge t. ready is 0 during t+1 … t+8; valid is high in cycle t+9 only. A second en held from t+1 is accepted at t+9.
- Overflow: all coefficients 127, x = 127 for eight samples, SHIFT=7. The eighth y is 127 with FIR_SAT_EN and −16 (0xF0) without it.
- Flush mid-MAC: flush asserted at t+4 after an accepted sample. No valid follows, y is unchanged and ready = 1 at t+5. The next impulse reproduces the clean impulse response.
- Coefficient write while busy: during MAC, write 0 to address 0. It is ignored, and the output equals the pre-write result. The same write issued in IDLE takes effect on the next sample.
- Asynchronous reset at t+3 of a computation: all outputs and registers reach their reset values immediately with no clock. After release, coefficients read back as 0, so the next output is 0.

Source files
------------

// File: rtl/fir_folded_param.sv
// fir_folded_param: folded FIR filter. One signed multiply-accumulate unit is
// time-shared over TAPS coefficients held in a run-time writable bank.
//
// Parameters
//   TAPS   number of taps (>= 2)
//   DW     signed input sample width
//   CW     signed coefficient width
//   OW     signed output width (>= 2)
//   SHIFT  arithmetic right shift applied to the final sum before output
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   en         sample strobe, accepted when en && ready
//   x          signed input sample
//   flush      synchronous clear of delay line / accumulator, aborts a computation
//   coef_we    coefficient write enable (honoured only while ready)
//   coef_addr  coefficient index, 0 multiplies the newest sample
//   coef_data  signed coefficient value
//   ready      high while idle (a sample or coefficient write can be taken)
//   valid      one-cycle strobe, y is new
//   y          signed filter output, held between strobes
//
// Build option
//   FIR_SAT_EN  when defined the scaled sum is clamped to the OW range,
//               otherwise it wraps to its low OW bits.
module fir_folded_param #(
    parameter int unsigned TAPS  = 8,
    parameter int unsigned DW    = 8,
    parameter int unsigned CW    = 8,
    parameter int unsigned OW    = 8,
    parameter int unsigned SHIFT = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic signed [DW-1:0]        x,
    input  logic                        flush,
    input  logic                        coef_we,
    input  logic [$clog2(TAPS)-1:0]     coef_addr,
    input  logic signed [CW-1:0]        coef_data,
    output logic                        ready,
    output logic                        valid,
    output logic signed [OW-1:0]        y
);

    localparam int unsigned AW    = $clog2(TAPS);
    localparam int unsigned PW    = DW + CW;
    localparam int unsigned ACC_W = DW + CW + $clog2(TAPS);

    typedef enum logic {
        IDLE = 1'b0,
        MAC  = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   accept;
    logic                   last;

    logic signed [DW-1:0]   dline [TAPS];
    logic signed [CW-1:0]   coef  [TAPS];
    logic signed [ACC_W-1:0] acc_q;
    logic [AW-1:0]          idx_q;

    logic signed [PW-1:0]   prod;
    logic signed [ACC_W-1:0] sum;
    logic signed [OW-1:0]   scaled;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle control strobes; flush overrides everything
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    accept  = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                if (idx_q == AW'(TAPS - 1)) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            accept  = 1'b0;
            last    = 1'b0;
            state_d = IDLE;
        end
    end

    assign ready = (state_q == IDLE);

    // Single MAC: both operands widened to the full product width first
    always_comb begin
        prod = PW'(dline[idx_q]) * PW'(coef[idx_q]);
        sum  = acc_q + ACC_W'(prod);
    end

`ifdef FIR_SAT_EN
    localparam int unsigned EW = ((ACC_W > OW) ? ACC_W : OW) + 1;
    localparam logic signed [EW-1:0] MAX_V = {{(EW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_V = {{(EW - OW + 1){1'b1}}, {(OW - 1){1'b0}}};

    logic signed [EW-1:0] wide;

    // Floor shift, then clamp into the signed OW range
    always_comb begin
        wide = EW'(sum >>> SHIFT);
        if (wide > MAX_V) begin
            scaled = MAX_V[OW-1:0];
        end else if (wide < MIN_V) begin
            scaled = MIN_V[OW-1:0];
        end else begin
            scaled = wide[OW-1:0];
        end
    end
`else
    // Floor shift, then keep the low OW bits (two's-complement wrap)
    always_comb begin
        scaled = OW'(sum >>> SHIFT);
    end
`endif

    // Delay line, accumulator, tap index, coefficient bank and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                dline[i] <= '0;
                coef[i]  <= '0;
            end
            acc_q <= '0;
            idx_q <= '0;
            y     <= '0;
            valid <= 1'b0;
        end else begin
            valid <= last;
            if (last) begin
                y <= scaled;
            end

            // Writes only land while idle, so a computation sees a stable bank
            if (coef_we && ready && (32'(coef_addr) < TAPS)) begin
                coef[coef_addr] <= coef_data;
            end

            if (flush) begin
                for (int unsigned i = 0; i < TAPS; i++) begin
                    dline[i] <= '0;
                end
                acc_q <= '0;
                idx_q <= '0;
            end else if (accept) begin
                dline[0] <= x;
                for (int unsigned i = 1; i < TAPS; i++) begin
                    dline[i] <= dline[i-1];
                end
                acc_q <= '0;
                idx_q <= '0;
            end else if (state_q == MAC) begin
                acc_q <= sum;
                idx_q <= idx_q + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fir_folded_param.sv
// Testbench for fir_folded_param. Two instances share all inputs: the default
// configuration (OW=8, SHIFT=7) and a wide exact one (OW=16, SHIFT=0). Both are
// checked against a tap-sum reference model kept in the bench.
module tb_fir_folded_param;

    localparam int TAPS = 8;
    localparam int SH_M = 7;
    localparam int OW_M = 8;
    localparam int SH_I = 0;
    localparam int OW_I = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic signed [7:0]  x;
    logic               flush;
    logic               coef_we;
    logic [2:0]         coef_addr;
    logic signed [7:0]  coef_data;
    logic               ready_m, valid_m;
    logic signed [7:0]  y_m;
    logic               ready_i, valid_i;
    logic signed [15:0] y_i;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: samples newest-first and coefficients
    int md [TAPS];
    int mc [TAPS];

    typedef struct {
        int     x;
        longint exp_imp;
    } vec_t;
    vec_t imp_tab [9];

    always #5 clk = ~clk;

    fir_folded_param u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .x         (x),
        .flush     (flush),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .ready     (ready_m),
        .valid     (valid_m),
        .y         (y_m)
    );

    fir_folded_param #(.OW(16), .SHIFT(0)) u_imp (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .x         (x),
        .flush     (flush),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .ready     (ready_i),
        .valid     (valid_i),
        .y         (y_i)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic longint ref_sum();
        longint s = 0;
        for (int k = 0; k < TAPS; k++) s += longint'(md[k]) * longint'(mc[k]);
        return s;
    endfunction

    function automatic longint scale_ref(input longint s, input int sh, input int ow);
        longint v, lim;
        v = s >>> sh;
`ifdef FIR_SAT_EN
        lim = longint'(1) <<< (ow - 1);
        if (v > lim - 1) v = lim - 1;
        if (v < -lim) v = -lim;
`else
        lim = longint'(1) <<< ow;
        v = v & (lim - 1);
        if (v >= lim / 2) v -= lim;
`endif
        return v;
    endfunction

    task automatic model_accept(input int xv);
        for (int k = TAPS - 1; k > 0; k--) md[k] = md[k-1];
        md[0] = xv;
    endtask

    task automatic model_clear_dline();
        for (int k = 0; k < TAPS; k++) md[k] = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        for (int n = 0; n < 20; n++) begin
            if (ready_m) break;
            step();
        end
        check({tag, " ready"}, ready_m, 1);
    endtask

    // Waits for the strobe and checks latency plus both outputs against sum s
    task automatic wait_valid(input string tag, input int exp_lat, input longint s);
        int lat = -1;
        for (int n = 0; n < TAPS + 4; n++) begin
            if (valid_m) begin
                lat = n;
                break;
            end
            step();
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " valid16"}, valid_i, 1);
        check({tag, " y8"}, y_m, scale_ref(s, SH_M, OW_M));
        check({tag, " y16"}, y_i, scale_ref(s, SH_I, OW_I));
    endtask

    task automatic send_w(input int xv, input bit we, input int addr, input int data,
                          input string tag);
        wait_ready(tag);
        en        = 1'b1;
        x         = 8'(xv);
        coef_we   = we;
        coef_addr = 3'(addr);
        coef_data = 8'(data);
        step();
        en      = 1'b0;
        coef_we = 1'b0;
        if (we) mc[addr] = data;
        model_accept(xv);
        wait_valid(tag, TAPS, ref_sum());
    endtask

    task automatic send(input int xv, input string tag);
        send_w(xv, 1'b0, 0, 0, tag);
    endtask

    task automatic write_coef(input int addr, input int data);
        wait_ready("wr");
        coef_we   = 1'b1;
        coef_addr = 3'(addr);
        coef_data = 8'(data);
        step();
        coef_we = 1'b0;
        mc[addr] = data;
    endtask

    task automatic flush_idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
        model_clear_dline();
    endtask

    task automatic run_impulse(input string tag);
        for (int i = 0; i < 9; i++) begin
            send(imp_tab[i].x, $sformatf("%s%0d", tag, i));
            check($sformatf("%s%0d tab", tag, i), y_i, imp_tab[i].exp_imp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        longint s_a, s_b;
        longint yprev_m, yprev_i;
        int     nv;

        for (int i = 0; i < 9; i++) begin
            imp_tab[i].x       = (i == 0) ? 1 : 0;
            imp_tab[i].exp_imp = (i < 8) ? longint'(i + 1) : 0;
        end
        for (int k = 0; k < TAPS; k++) begin
            md[k] = 0;
            mc[k] = 0;
        end

        rst = 1'b0; en = 1'b0; x = '0; flush = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst ready", ready_m, 1);
        check("rst valid", valid_m, 0);
        check("rst y8", y_m, 0);
        check("rst ready16", ready_i, 1);
        check("rst y16", y_i, 0);
        rst = 1'b1;
        step();

        // Impulse response with coefficients 1..8
        for (int a = 0; a < TAPS; a++) write_coef(a, a + 1);
        run_impulse("imp");

        // Latency and handshake: second sample held from t+1, taken at t+9
        wait_ready("hs");
        en = 1'b1; x = 8'(5);
        step();
        model_accept(5);
        s_a = ref_sum();
        x = -8'sd3;
        for (int k = 1; k <= TAPS; k++) begin
            check($sformatf("hs ready t+%0d", k), ready_m, 0);
            check($sformatf("hs valid t+%0d", k), valid_m, 0);
            step();
        end
        check("hs valid t+9", valid_m, 1);
        check("hs ready t+9", ready_m, 1);
        check("hs y16 a", y_i, scale_ref(s_a, SH_I, OW_I));
        model_accept(-3);
        s_b = ref_sum();
        step();
        en = 1'b0;
        check("hs valid t+10", valid_m, 0);
        check("hs b taken", ready_m, 0);
        wait_valid("hs b", TAPS, s_b);

        // Flush mid-computation
        yprev_m = y_m;
        yprev_i = y_i;
        wait_ready("fl");
        en = 1'b1; x = 8'(9);
        step();
        en = 1'b0;
        step(); step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        model_clear_dline();
        check("fl ready", ready_m, 1);
        check("fl valid", valid_m, 0);
        check("fl y8 held", y_m, yprev_m);
        check("fl y16 held", y_i, yprev_i);
        nv = 0;
        for (int n = 0; n < 12; n++) begin
            if (valid_m || valid_i) nv++;
            step();
        end
        check("fl no valid", nv, 0);
        run_impulse("imp2_");

        // Coefficient write while busy is ignored
        wait_ready("cwb");
        en = 1'b1; x = 8'(20);
        step();
        en = 1'b0;
        model_accept(20);
        s_a = ref_sum();
        step();
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 8'sd0;
        step();
        coef_we = 1'b0;
        wait_valid("cw busy", TAPS - 2, s_a);
        // Same write while idle takes effect; then a write together with a sample
        write_coef(0, 0);
        send(20, "cw idle");
        send_w(-11, 1'b1, 1, -7, "cw with en");

        // Overflow: all 127
        for (int a = 0; a < TAPS; a++) write_coef(a, 127);
        for (int i = 0; i < TAPS; i++) send(127, $sformatf("ovf%0d", i));
`ifdef FIR_SAT_EN
        check("ovf final y8", y_m, 127);
`else
        check("ovf final y8", y_m, -16);
`endif

        // Randomized traffic against the model
        for (int it = 0; it < 150; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) flush_idle();
            if (r <= 3) write_coef(int'($urandom_range(0, TAPS - 1)),
                                   int'($urandom_range(0, 255)) - 128);
            send_w(int'($urandom_range(0, 255)) - 128,
                   ($urandom_range(0, 3) == 0),
                   int'($urandom_range(0, TAPS - 1)),
                   int'($urandom_range(0, 255)) - 128,
                   $sformatf("rnd%0d", it));
        end

        // Asynchronous reset in the middle of a computation
        wait_ready("ar");
        en = 1'b1; x = 8'(33);
        step();
        en = 1'b0;
        step(); step();
        #2;
        rst = 1'b0;
        #1;
        check("ar ready", ready_m, 1);
        check("ar valid", valid_m, 0);
        check("ar y8", y_m, 0);
        check("ar y16", y_i, 0);
        step(); step();
        rst = 1'b1;
        for (int k = 0; k < TAPS; k++) begin
            md[k] = 0;
            mc[k] = 0;
        end
        step();
        send(77, "post rst");
        check("post rst y16 zero", y_i, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
